inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Multi-cycle instruction fetch unit for the RV32E single-issue core. It holds the architectural PC and fetches one instruction at a time from instruction memory over a valid/ready request/response interface. It presents `inst`/`pc_cur` to the decode and register-file stage, and holds them stable until that stage commits. At commit it sequences to `pc+4`, or to a redirect target for branch, jump, ecall or mret.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC loaded by reset.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `mem_req_valid` output 1: fetch request valid.
- `mem_req_ready` input 1: memory accepts request.
- `mem_req_addr` output 32: fetch address, equal to `pc_cur`.
- `mem_rsp_valid` input 1: response data valid.
- `mem_rsp_data` input 32: fetched instruction word.
- `mem_rsp_err` input 1: bus error on this response.
- `inst_valid` output 1: `inst`/`pc_cur` hold a fetched instruction.
- `inst_ready` input 1: downstream commits current instruction this cycle.
- `jump_en` input 1: redirect at commit; sampled only when `inst_valid && inst_ready`.
- `jump_target` input 32: redirect PC.
- `halt` input 1: ebreak; sampled only at commit; stops fetching.
- `pc_cur` output 32: PC of current instruction.
- `inst` output 32: current instruction word.
- `ifu_signal` output 1: sticky error flag; must stay 0 in correct operation.

## Operation
- States: BOOT, REQ, WAIT, HOLD, HALT, ERR.
- Reset values: state=BOOT, `pc_cur`=RESET_PC, `inst`=`32'h0000_0013`, `inst_valid`=0, `mem_req_valid`=0, `ifu_signal`=0.
- BOOT -> REQ unconditionally on the first cycle with `rst` low.
- REQ: `mem_req_valid`=1, `mem_req_addr`=`pc_cur`. When `mem_req_ready`=1, go to WAIT.
- WAIT: `mem_rsp_valid`=1 with `mem_rsp_err`=0 latches `inst`<=`mem_rsp_data` and goes to HOLD. With `mem_rsp_err`=1, go to ERR and leave `inst` unchanged.
- HOLD: `inst_valid`=1; `inst` and `pc_cur` are stable. On `inst_ready`=1 (commit), apply these in priority order:
  - `halt` -> HALT, `pc_cur` unchanged.
  - else `jump_en` -> `pc_cur`<=`jump_target`, go to REQ.
  - else `pc_cur`<=`pc_cur`+4 (mod 2^32, wraps `FFFF_FFFC`->`0000_0000`), go to REQ.
- HALT: all outputs idle, `inst_valid`=0. Exit only by reset.
- ERR: `ifu_signal`=1, `inst_valid`=0, `mem_req_valid`=0. Exit only by reset.
- `mem_rsp_valid` in any state other than WAIT is ignored.
- `inst_ready` outside HOLD is ignored.
- Reset asserted in any state takes effect at that posedge: state=BOOT and all registers return to their reset values. A response still in flight for an abandoned request arrives in BOOT or REQ and is ignored.

## Timing
- `mem_req_valid`, `inst_valid` and `ifu_signal` are decoded from registered state only. None depends combinationally on inputs.
- Memory must not respond in the cycle its request is accepted. A response is earliest one cycle after the REQ handshake.
- Best case, zero-wait memory: commit in cycle t, REQ in t+1 (accepted), WAIT in t+2 (response), `inst_valid` in t+3. Three cycles per instruction.
- First instruction after reset release in cycle r: `inst_valid` earliest in r+3. The cycle r itself is spent in BOOT.
- `mem_req_valid` stays high in REQ until accepted. `mem_req_addr` must not change while waiting.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined: at commit with `jump_en`=1 and `jump_target[1:0]`!=0, go to ERR instead of REQ and set `ifu_signal`=1. `pc_cur` keeps the committed instruction's PC.
- Undefined: `jump_target[1:0]` is discarded and `pc_cur`<={`jump_target[31:2]`,2'b00}, with no error.

## Test plan
- Reset then zero-wait memory returning `32'h00100093` at `8000_0000`: `inst_valid` at r+3 with `pc_cur`=`8000_0000`. Commit gives next `mem_req_addr`=`8000_0004`.
- `mem_req_ready` held low 5 cycles: `mem_req_valid` stays high and `mem_req_addr` stays constant. Response 4 cycles after acceptance: `inst_valid` follows one cycle later.
- Commit with `jump_en`=1, `jump_target`=`8000_0100`: next request address `8000_0100`. `jump_en`=1 while `inst_ready`=0: no effect.
- `mem_rsp_err`=1 in WAIT: `ifu_signal`=1 and no further requests; only reset clears the error. Commit with `halt`=1: no further requests, `pc_cur` held.
- Misaligned target `8000_0102`:
  - with `IFU_ALIGN_CHECK_EN`: ERR, `ifu_signal`=1.
  - without it: fetch from `8000_0100`.
- Reset asserted during WAIT while memory responds on the same cycle: response ignored, `inst`=`32'h0000_0013`, first new request to `RESET_PC`. `pc_cur`=`FFFF_FFFC` and commit: next request to `0000_0000`.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multi-cycle instruction fetch unit for the RV32E core.
// Holds the architectural PC and fetches one instruction at a time over a
// valid/ready memory interface. The current instruction is held for the
// decode stage until it commits, then the PC moves to pc+4 or to a redirect.
// Optional feature macro: IFU_ALIGN_CHECK_EN
//   defined   -> a misaligned jump target at commit traps into the ERR state
//   undefined -> the low two bits of the jump target are dropped
`timescale 1ns/1ps

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] pc_cur,
    output logic [31:0] inst,
    output logic        ifu_signal
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        HALT,
        ERR
    } state_t;

    state_t state;

`ifndef IFU_ALIGN_CHECK_EN
    // The low target bits are intentionally dropped when alignment is not checked.
    logic unused_target_bits;
    assign unused_target_bits = ^jump_target[1:0];
`endif

    // Handshake and status outputs come from the state register alone, so no
    // input can reach them combinationally.
    assign mem_req_valid = (state == REQ);
    assign inst_valid    = (state == HOLD);
    assign ifu_signal    = (state == ERR);
    assign mem_req_addr  = pc_cur;

    // Fetch sequencer: request, wait for the response, hold until commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= BOOT;
            pc_cur <= RESET_PC;
            inst   <= NOP_INST;
        end else begin
            case (state)
                BOOT: begin
                    state <= REQ;
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (mem_rsp_err) begin
                            state <= ERR;
                        end else begin
                            inst  <= mem_rsp_data;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        if (halt) begin
                            state <= HALT;
                        end else if (jump_en) begin
`ifdef IFU_ALIGN_CHECK_EN
                            if (jump_target[1:0] != 2'b00) begin
                                state <= ERR;
                            end else begin
                                pc_cur <= jump_target;
                                state  <= REQ;
                            end
`else
                            pc_cur <= {jump_target[31:2], 2'b00};
                            state  <= REQ;
`endif
                        end else begin
                            pc_cur <= pc_cur + 32'd4;
                            state  <= REQ;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: randomized fetch/commit traffic checked
// against a PC-sequence model, plus directed corner scenarios.
`timescale 1ns/1ps

module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        mem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] pc_cur;
    logic [31:0] inst;
    logic        ifu_signal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_err  (mem_rsp_err),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .halt         (halt),
        .pc_cur       (pc_cur),
        .inst         (inst),
        .ifu_signal   (ifu_signal)
    );

    // Free-running clock and edge counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference PC rule at commit without halt.
    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic j,
                                                  input logic [31:0] tgt);
        logic [31:0] aligned;
        aligned = tgt & 32'hFFFF_FFFC;
        return j ? aligned : pc + 32'd4;
    endfunction

    // Hold reset for two edges; returns in the first cycle with reset low.
    task automatic apply_reset();
        rst = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
        inst_ready = 1'b0;
        jump_en = 1'b0;
        halt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait for a request, stall it, then accept it; reports address and stability.
    task automatic do_request(input int stall, output logic [31:0] addr, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        addr = 32'h0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req_valid) begin
            ok = 1'b0;
            return;
        end
        addr = mem_req_addr;
        for (int i = 0; i < stall; i++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rsp_err = 1'b1;
            mem_rsp_data = $urandom;
            tick();
            if (!mem_req_valid || mem_req_addr !== addr) ok = 1'b0;
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    // Respond on the lat-th cycle after acceptance (lat >= 1).
    task automatic do_response(input int lat, input logic [31:0] data, input logic err);
        for (int i = 1; i < lat; i++) tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = data;
        mem_rsp_err = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
    endtask

    task automatic do_commit(input logic j, input logic [31:0] tgt, input logic h);
        inst_ready = 1'b1;
        jump_en = j;
        jump_target = tgt;
        halt = h;
        tick();
        inst_ready = 1'b0;
        jump_en = 1'b0;
        halt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (pc_cur !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected %h", pc_cur, RESET_PC);
        end
        checks++;
        if (inst !== NOP_INST) begin
            errors++;
            $display("[TB] FAIL reset_inst: got %h expected %h", inst, NOP_INST);
        end
        checks++;
        if ({inst_valid, mem_req_valid, ifu_signal} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000",
                     {inst_valid, mem_req_valid, ifu_signal});
        end
        rst = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boot_no_req: got %b expected 0", mem_req_valid);
        end
    endtask

    task automatic test_first_fetch();
        logic [31:0] addr;
        bit ok;
        int r;
        apply_reset();
        r = cyc;
        do_request(0, addr, ok);
        checks++;
        if (!ok || addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL first_req_addr: got %h ok=%0d expected %h", addr, ok, RESET_PC);
        end
        do_response(1, 32'h0010_0093, 1'b0);
        checks++;
        if (cyc - r !== 3 || inst_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_latency: got %0d cycles valid=%b expected 3 cycles valid=1",
                     cyc - r, inst_valid);
        end
        checks++;
        if (inst !== 32'h0010_0093 || pc_cur !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL first_inst: got %h@%h expected 00100093@%h", inst, pc_cur, RESET_PC);
        end
        do_commit(1'b0, 32'h0, 1'b0);
        do_request(0, addr, ok);
        checks++;
        if (!ok || addr !== RESET_PC + 32'd4) begin
            errors++;
            $display("[TB] FAIL seq_req_addr: got %h expected %h", addr, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_stall();
        logic [31:0] addr;
        bit ok;
        int a;
        apply_reset();
        do_request(5, addr, ok);
        a = cyc;
        checks++;
        if (!ok || addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL stall_req_stable: got %h ok=%0d expected %h stable", addr, ok, RESET_PC);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_wait_valid: got %b expected 0", inst_valid);
        end
        do_response(4, 32'h1234_5678, 1'b0);
        checks++;
        if (cyc - a !== 4 || inst_valid !== 1'b1 || inst !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL stall_rsp: got %0d cycles valid=%b inst=%h expected 4 1 12345678",
                     cyc - a, inst_valid, inst);
        end
    endtask

    task automatic test_jump();
        logic [31:0] addr;
        bit ok;
        bit stable;
        apply_reset();
        do_request(0, addr, ok);
        do_response(1, 32'h0000_006F, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            jump_en = 1'b1;
            jump_target = $urandom;
            tick();
            if (!inst_valid || mem_req_valid || pc_cur !== RESET_PC || inst !== 32'h0000_006F)
                stable = 1'b0;
        end
        jump_en = 1'b0;
        checks++;
        if (!stable) begin
            errors++;
            $display("[TB] FAIL jump_without_commit: got pc=%h valid=%b expected pc=%h valid=1",
                     pc_cur, inst_valid, RESET_PC);
        end
        do_commit(1'b1, 32'h8000_0100, 1'b0);
        do_request(0, addr, ok);
        checks++;
        if (!ok || addr !== 32'h8000_0100) begin
            errors++;
            $display("[TB] FAIL jump_req_addr: got %h expected 80000100", addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] exp_pc;
        logic [31:0] data;
        logic [31:0] tgt;
        logic        j;
        bit ok;
        bit stable;
        apply_reset();
        exp_pc = RESET_PC;
        for (int n = 0; n < 25; n++) begin
            do_request($urandom_range(0, 3), addr, ok);
            checks++;
            if (!ok || addr !== exp_pc) begin
                errors++;
                $display("[TB] FAIL rand_req_addr[%0d]: got %h ok=%0d expected %h", n, addr, ok, exp_pc);
            end
            data = $urandom;
            do_response($urandom_range(1, 4), data, 1'b0);
            stable = 1'b1;
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                jump_en = 1'($urandom_range(0, 1));
                halt = 1'($urandom_range(0, 1));
                tick();
                if (!inst_valid || inst !== data || pc_cur !== exp_pc) stable = 1'b0;
            end
            jump_en = 1'b0;
            halt = 1'b0;
            checks++;
            if (!stable || inst_valid !== 1'b1 || inst !== data || pc_cur !== exp_pc) begin
                errors++;
                $display("[TB] FAIL rand_hold[%0d]: got %h@%h valid=%b expected %h@%h valid=1",
                         n, inst, pc_cur, inst_valid, data, exp_pc);
            end
            j = ($urandom_range(0, 2) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            do_commit(j, tgt, 1'b0);
            exp_pc = model_next_pc(exp_pc, j, tgt);
        end
    endtask

    task automatic test_error();
        logic [31:0] addr;
        bit ok;
        bit quiet;
        apply_reset();
        do_request(0, addr, ok);
        do_response(1, 32'hCAFE_0013, 1'b0);
        do_commit(1'b0, 32'h0, 1'b0);
        do_request(1, addr, ok);
        do_response(2, 32'hDEAD_DEAD, 1'b1);
        checks++;
        if ({ifu_signal, inst_valid, mem_req_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL err_flags: got %b expected 100", {ifu_signal, inst_valid, mem_req_valid});
        end
        checks++;
        if (inst !== 32'hCAFE_0013) begin
            errors++;
            $display("[TB] FAIL err_inst_kept: got %h expected cafe0013", inst);
        end
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'($urandom_range(0, 1));
            inst_ready = 1'b1;
            tick();
            if (mem_req_valid || !ifu_signal || inst_valid) quiet = 1'b0;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        inst_ready = 1'b0;
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL err_sticky: got req=%b sig=%b expected req=0 sig=1", mem_req_valid, ifu_signal);
        end
        apply_reset();
        checks++;
        if (ifu_signal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_cleared: got %b expected 0", ifu_signal);
        end
    endtask

    task automatic test_halt();
        logic [31:0] addr;
        bit ok;
        bit quiet;
        apply_reset();
        do_request(0, addr, ok);
        do_response(1, 32'h0010_0073, 1'b0);
        do_commit(1'b1, 32'h8000_0200, 1'b1);
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_req_ready = 1'b1;
            inst_ready = 1'b1;
            tick();
            if (mem_req_valid || inst_valid || ifu_signal || pc_cur !== RESET_PC) quiet = 1'b0;
        end
        mem_req_ready = 1'b0;
        inst_ready = 1'b0;
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL halt_idle: got req=%b valid=%b pc=%h expected 0 0 %h",
                     mem_req_valid, inst_valid, pc_cur, RESET_PC);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addr;
        bit ok;
        apply_reset();
        do_request(0, addr, ok);
        do_response(1, 32'h0000_0067, 1'b0);
        do_commit(1'b1, 32'h8000_0102, 1'b0);
`ifdef IFU_ALIGN_CHECK_EN
        checks++;
        if (ifu_signal !== 1'b1 || mem_req_valid !== 1'b0 || pc_cur !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL misalign_trap: got sig=%b req=%b pc=%h expected 1 0 %h",
                     ifu_signal, mem_req_valid, pc_cur, RESET_PC);
        end
`else
        do_request(0, addr, ok);
        checks++;
        if (!ok || addr !== 32'h8000_0100 || ifu_signal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_fetch: got %h sig=%b expected 80000100 sig=0", addr, ifu_signal);
        end
`endif
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] addr;
        bit ok;
        apply_reset();
        do_request(0, addr, ok);
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hDEAD_BEEF;
        mem_rsp_err = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (inst !== NOP_INST || pc_cur !== RESET_PC || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wait_state: got %h@%h valid=%b expected %h@%h valid=0",
                     inst, pc_cur, inst_valid, NOP_INST, RESET_PC);
        end
        tick();
        tick();
        mem_rsp_valid = 1'b0;
        checks++;
        if (inst !== NOP_INST || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_stale_rsp: got %h valid=%b expected %h valid=0", inst, inst_valid, NOP_INST);
        end
        do_request(0, addr, ok);
        checks++;
        if (!ok || addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL rst_first_req: got %h expected %h", addr, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addr;
        bit ok;
        apply_reset();
        do_request(0, addr, ok);
        do_response(1, 32'h0000_006F, 1'b0);
        do_commit(1'b1, 32'hFFFF_FFFC, 1'b0);
        do_request(2, addr, ok);
        do_response(3, 32'h0000_0013, 1'b0);
        checks++;
        if (!ok || pc_cur !== 32'hFFFF_FFFC || inst_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_pc: got %h valid=%b expected fffffffc valid=1", pc_cur, inst_valid);
        end
        do_commit(1'b0, 32'h0, 1'b0);
        do_request(0, addr, ok);
        checks++;
        if (!ok || addr !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL wrap_req_addr: got %h expected 00000000", addr);
        end
    endtask

    // Scenario sequence and final summary.
    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_jump();
        test_random();
        test_error();
        test_halt();
        test_misaligned();
        test_reset_in_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
